// File: rtl/signal_validation_filter_pkg.sv
// Shared types and helpers for the signal validation filter.
// Holds the channel state encoding and a saturating counter increment.
package signal_validation_pkg;

   typedef enum logic [1:0] {
      ST_OFF      = 2'd0,
      ST_QUAL_ON  = 2'd1,
      ST_ON       = 2'd2,
      ST_QUAL_OFF = 2'd3
   } state_e;

   localparam int unsigned MAX_CNT_BITS = 32;

   // Width-parameterised through w; the caller truncates to its own width.
   function automatic logic [MAX_CNT_BITS-1:0] sat_inc(
      input logic [MAX_CNT_BITS-1:0] v,
      input int unsigned             w
   );
      logic [MAX_CNT_BITS-1:0] top;
      top = (w >= MAX_CNT_BITS) ? '1 : ((MAX_CNT_BITS'(1) << w) - 1'b1);
      return (v >= top) ? top : v + 1'b1;
   endfunction

   function automatic logic st_is_done(input state_e s);
      return (s == ST_ON) || (s == ST_QUAL_OFF);
   endfunction

   function automatic logic st_is_busy(input state_e s);
      return (s == ST_QUAL_ON) || (s == ST_QUAL_OFF);
   endfunction

endpackage

// File: rtl/signal_validation_filter_if.sv
// Control/status bundle of the signal validation filter.
// The master side drives enables, raw inputs and windows; the slave side reports status.
interface signal_validation_filter_if #(
   parameter int CHANNELS = 4,
   parameter int CNT_BITS = 8
);
   logic                iCE;
   logic [CHANNELS-1:0] ivEnable;
   logic [CHANNELS-1:0] ivIn;
   logic [CNT_BITS-1:0] ivOnCnt;
   logic [CNT_BITS-1:0] ivOffCnt;
   logic [CHANNELS-1:0] ovDone;
   logic [CHANNELS-1:0] ovRise;
   logic [CHANNELS-1:0] ovFall;
   logic [CHANNELS-1:0] ovBusy;

   modport master (
      output iCE, ivEnable, ivIn, ivOnCnt, ivOffCnt,
      input  ovDone, ovRise, ovFall, ovBusy
   );

   modport slave (
      input  iCE, ivEnable, ivIn, ivOnCnt, ivOffCnt,
      output ovDone, ovRise, ovFall, ovBusy
   );
endinterface

// File: rtl/signal_validation_filter_channel.sv
// One hysteretic validation channel: FSM, saturating tick counter and edge pulses.
// Status outputs are direct decodes of registered state.
module signal_validation_channel
   import signal_validation_pkg::*;
#(
   parameter int   CNT_BITS = 8,
   parameter logic IN_POL   = 1'b1,
   parameter logic OUT_POL  = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ce,
   input  logic                enable,
   input  logic                in_raw,
   input  logic [CNT_BITS-1:0] on_cnt,
   input  logic [CNT_BITS-1:0] off_cnt,
   output logic                done,
   output logic                rise,
   output logic                fall,
   output logic                busy
);

   state_e              state_q, state_d;
   logic [CNT_BITS-1:0] cnt_q, cnt_d;
   logic                rise_q, rise_d;
   logic                fall_q, fall_d;
   logic                asserted;
   logic [CNT_BITS-1:0] cnt_inc;

   assign asserted = (in_raw == IN_POL);
   assign cnt_inc  = CNT_BITS'(sat_inc(MAX_CNT_BITS'(cnt_q), CNT_BITS));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (!enable) begin
         state_d = ST_OFF;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            ST_OFF: begin
               if (asserted) begin
                  state_d = ST_QUAL_ON;
                  cnt_d   = '0;
               end
            end
            ST_QUAL_ON: begin
               if (!asserted) begin
                  state_d = ST_OFF;
                  cnt_d   = '0;
               end else if (cnt_q >= on_cnt) begin
                  state_d = ST_ON;
                  cnt_d   = '0;
               end else if (ce) begin
                  cnt_d = cnt_inc;
               end
            end
            ST_ON: begin
               if (!asserted) begin
                  state_d = ST_QUAL_OFF;
                  cnt_d   = '0;
               end
            end
            ST_QUAL_OFF: begin
               if (asserted) begin
                  state_d = ST_ON;
                  cnt_d   = '0;
               end else if (cnt_q >= off_cnt) begin
                  state_d = ST_OFF;
                  cnt_d   = '0;
               end else if (ce) begin
                  cnt_d = cnt_inc;
               end
            end
            default: begin
               state_d = ST_OFF;
               cnt_d   = '0;
            end
         endcase
      end
      // Pulses line up with the first cycle the new level is visible.
      rise_d = !st_is_done(state_q) && st_is_done(state_d);
      fall_d = st_is_done(state_q) && !st_is_done(state_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_OFF;
         cnt_q   <= '0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign done = st_is_done(state_q) ? OUT_POL : ~OUT_POL;
   assign busy = st_is_busy(state_q);
   assign rise = rise_q;
   assign fall = fall_q;

endmodule

// File: rtl/signal_validation_filter.sv
// Multi-channel validation filter: fans shared controls out to independent channels.
// Each channel qualifies assertion and deassertion over its own tick window.
module signal_validation_filter
   import signal_validation_pkg::*;
#(
   parameter int   CHANNELS = 4,
   parameter int   CNT_BITS = 8,
   parameter logic IN_POL   = 1'b1,
   parameter logic OUT_POL  = 1'b1
) (
   input  logic                         iClk,
   input  logic                         iRst,
   signal_validation_filter_if.slave    bus
);

   logic [CHANNELS-1:0] done_v;
   logic [CHANNELS-1:0] rise_v;
   logic [CHANNELS-1:0] fall_v;
   logic [CHANNELS-1:0] busy_v;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      signal_validation_channel #(
         .CNT_BITS (CNT_BITS),
         .IN_POL   (IN_POL),
         .OUT_POL  (OUT_POL)
      ) u_ch (
         .clk     (iClk),
         .rst     (iRst),
         .ce      (bus.iCE),
         .enable  (bus.ivEnable[i]),
         .in_raw  (bus.ivIn[i]),
         .on_cnt  (bus.ivOnCnt),
         .off_cnt (bus.ivOffCnt),
         .done    (done_v[i]),
         .rise    (rise_v[i]),
         .fall    (fall_v[i]),
         .busy    (busy_v[i])
      );
   end

   assign bus.ovDone = done_v;
   assign bus.ovRise = rise_v;
   assign bus.ovFall = fall_v;
   assign bus.ovBusy = busy_v;

endmodule

// File: tb/tb_signal_validation_filter.sv
// Directed bench for signal_validation_filter with hand-computed expectations.
// Checks are sampled 1 time unit after each rising edge.
module tb_signal_validation_filter;

   localparam int CH = 4;
   localparam int CB = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;

   signal_validation_filter_if #(.CHANNELS(CH), .CNT_BITS(CB)) bus ();

   signal_validation_filter #(
      .CHANNELS (CH),
      .CNT_BITS (CB),
      .IN_POL   (1'b1),
      .OUT_POL  (1'b1)
   ) dut (
      .iClk (clk),
      .iRst (rst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [3:0] d,
                          input logic [3:0] r, input logic [3:0] f,
                          input logic [3:0] b);
      chk({tag, ".done"}, 32'(bus.ovDone), 32'(d));
      chk({tag, ".rise"}, 32'(bus.ovRise), 32'(r));
      chk({tag, ".fall"}, 32'(bus.ovFall), 32'(f));
      chk({tag, ".busy"}, 32'(bus.ovBusy), 32'(b));
   endtask

   initial begin
      bus.iCE      = 1'b1;
      bus.ivEnable = 4'hF;
      bus.ivIn     = 4'hF;
      bus.ivOnCnt  = 8'd3;
      bus.ivOffCnt = 8'd2;

      // reset held two cycles with every input asserted
      rst = 1'b1;
      tick();
      chk_all("rst1", 4'h0, 4'h0, 4'h0, 4'h0);
      tick();
      chk_all("rst2", 4'h0, 4'h0, 4'h0, 4'h0);
      rst = 1'b0;
      tick();
      chk_all("post_rst_qual", 4'h0, 4'h0, 4'h0, 4'hF);
      bus.ivIn = 4'h0;
      tick();
      chk_all("abort_all", 4'h0, 4'h0, 4'h0, 4'h0);

      // ch0 qualifies with ivOnCnt=3: ON five edges after the input
      bus.ivIn = 4'h1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk_all("ch0_qual", 4'h0, 4'h0, 4'h0, 4'h1);
      end
      tick();
      chk_all("ch0_on", 4'h1, 4'h1, 4'h0, 4'h0);
      tick();
      chk_all("ch0_hold", 4'h1, 4'h0, 4'h0, 4'h0);

      // ch1 3-cycle glitch with ivOnCnt=5 is rejected
      bus.ivOnCnt = 8'd5;
      bus.ivIn    = 4'h3;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk_all("ch1_glitch", 4'h1, 4'h0, 4'h0, 4'h2);
      end
      bus.ivIn = 4'h1;
      tick();
      chk_all("ch1_reject", 4'h1, 4'h0, 4'h0, 4'h0);

      // ch2 to ON with ivOnCnt=0 (single edge of qualification)
      bus.ivOnCnt = 8'd0;
      bus.ivIn    = 4'h5;
      tick();
      chk_all("ch2_q0", 4'h1, 4'h0, 4'h0, 4'h4);
      tick();
      chk_all("ch2_on", 4'h5, 4'h4, 4'h0, 4'h0);

      // 2-cycle drop with ivOffCnt=2 is absorbed
      bus.ivIn = 4'h1;
      tick();
      chk_all("ch2_drop1", 4'h5, 4'h0, 4'h0, 4'h4);
      tick();
      chk_all("ch2_drop2", 4'h5, 4'h0, 4'h0, 4'h4);
      bus.ivIn = 4'h5;
      tick();
      chk_all("ch2_back", 4'h5, 4'h0, 4'h0, 4'h0);

      // held drop deasserts on the fourth edge
      bus.ivIn = 4'h1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk_all("ch2_offq", 4'h5, 4'h0, 4'h0, 4'h4);
      end
      tick();
      chk_all("ch2_off", 4'h1, 4'h0, 4'h4, 4'h0);
      tick();
      chk_all("ch2_off_hold", 4'h1, 4'h0, 4'h0, 4'h0);

      // ch3 with iCE toggling and ivOnCnt=2
      bus.ivOnCnt = 8'd2;
      bus.ivIn    = 4'h9;
      for (int k = 0; k < 5; k++) begin
         bus.iCE = (k % 2 == 0);
         tick();
         chk_all("ch3_ce_qual", 4'h1, 4'h0, 4'h0, 4'h8);
      end
      bus.iCE = 1'b0;
      tick();
      chk_all("ch3_ce_on", 4'h9, 4'h8, 4'h0, 4'h0);

      // ch1 drop while iCE=0 still aborts
      bus.iCE  = 1'b1;
      bus.ivIn = 4'hB;
      tick();
      chk_all("ch1_q", 4'h9, 4'h8 & 4'h0, 4'h0, 4'h2);
      bus.iCE = 1'b0;
      tick();
      chk_all("ch1_frozen", 4'h9, 4'h0, 4'h0, 4'h2);
      bus.ivIn = 4'h9;
      tick();
      chk_all("ch1_ce0_abort", 4'h9, 4'h0, 4'h0, 4'h0);

      // disabling ch3 drops it immediately with one fall pulse
      bus.iCE      = 1'b1;
      bus.ivEnable = 4'h7;
      tick();
      chk_all("ch3_dis", 4'h1, 4'h0, 4'h8, 4'h0);
      tick();
      chk_all("ch3_dis_hold", 4'h1, 4'h0, 4'h0, 4'h0);

      // ch0 off with ivOffCnt=0
      bus.ivEnable = 4'hF;
      bus.ivIn     = 4'h0;
      bus.ivOffCnt = 8'd0;
      tick();
      chk_all("ch0_offq", 4'h1, 4'h0, 4'h0, 4'h1);
      tick();
      chk_all("ch0_off", 4'h0, 4'h0, 4'h1, 4'h0);

      // reset mid-qualification clears state and count, no pulses
      bus.ivOnCnt = 8'd3;
      bus.ivIn    = 4'h1;
      tick();
      tick();
      chk_all("ch0_mid_q", 4'h0, 4'h0, 4'h0, 4'h1);
      rst = 1'b1;
      tick();
      chk_all("mid_rst", 4'h0, 4'h0, 4'h0, 4'h0);
      rst = 1'b0;
      bus.ivOnCnt = 8'd1;
      tick();
      chk_all("rq_a", 4'h0, 4'h0, 4'h0, 4'h1);
      tick();
      chk_all("rq_b", 4'h0, 4'h0, 4'h0, 4'h1);
      tick();
      chk_all("rq_on", 4'h1, 4'h1, 4'h0, 4'h0);

      // lowering ivOnCnt mid-qualification completes on the next edge
      bus.ivOnCnt = 8'd200;
      bus.ivIn    = 4'h3;
      for (int k = 0; k < 4; k++) tick();
      chk_all("live_q", 4'h1, 4'h0, 4'h0, 4'h2);
      bus.ivOnCnt = 8'd1;
      tick();
      chk_all("live_on", 4'h3, 4'h2, 4'h0, 4'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed no_finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
